// File: rtl/crc32_frame_tx.sv
// rtl/crc32_frame_tx.sv - byte-to-bit framer feeding a bit-serial CRC-32/MPEG-2 stage, appends CRC MSB first
module crc32_frame_tx #(
    parameter int INVERT_CRC = 0,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid_in,
    input  logic                 byte_last_in,
    output logic                 byte_ready_out,
    output logic                 crc_clear_out,
    output logic                 crc_valid_out,
    output logic                 crc_bit_out,
    input  logic [CRC_WIDTH-1:0] crc_in,
    output logic                 tx_valid_out,
    output logic                 tx_bit_out,
    output logic                 tx_last_out
);

    localparam int CW = $clog2(CRC_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DATA,
        S_WAIT,
        S_SETTLE,
        S_CRC
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0] crcreg_q, crcreg_d;

    logic ready_q, ready_d;
    logic clear_q, clear_d;
    logic cvalid_q, cvalid_d;
    logic cbit_q, cbit_d;
    logic tvalid_q, tvalid_d;
    logic tbit_q, tbit_d;
    logic tlast_q, tlast_d;

    logic accept;

    assign accept = byte_valid_in && ready_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        crcreg_d = crcreg_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = byte_in;
                    last_d  = byte_last_in;
                    cnt_d   = CW'(7);
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_DATA;
            S_DATA: begin
                shift_d = {shift_q[6:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    if (last_q) begin
                        state_d = S_SETTLE;
                    end else if (accept) begin
                        shift_d = byte_in;
                        last_d  = byte_last_in;
                        cnt_d   = CW'(7);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (accept) begin
                    shift_d = byte_in;
                    last_d  = byte_last_in;
                    cnt_d   = CW'(7);
                    state_d = S_DATA;
                end
            end
            S_SETTLE: begin
                // The CRC stage has absorbed the final payload bit by now.
                crcreg_d = (INVERT_CRC != 0) ? ~crc_in : crc_in;
                cnt_d    = CW'(CRC_WIDTH - 1);
                state_d  = S_CRC;
            end
            S_CRC: begin
                crcreg_d = {crcreg_q[CRC_WIDTH-2:0], 1'b0};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they land in flops alongside the state.
    always_comb begin
        ready_d  = (state_d == S_IDLE) || (state_d == S_WAIT) ||
                   ((state_d == S_DATA) && (cnt_d == '0) && !last_d);
        clear_d  = (state_d == S_CLEAR);
        cvalid_d = (state_d == S_DATA);
        cbit_d   = (state_d == S_DATA) && shift_d[7];
        tvalid_d = (state_d == S_DATA) || (state_d == S_CRC);
        tbit_d   = 1'b0;
        if (state_d == S_DATA) begin
            tbit_d = shift_d[7];
        end else if (state_d == S_CRC) begin
            tbit_d = crcreg_d[CRC_WIDTH-1];
        end
        tlast_d  = (state_d == S_CRC) && (cnt_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            crcreg_q <= '0;
            ready_q  <= 1'b1;
            clear_q  <= 1'b0;
            cvalid_q <= 1'b0;
            cbit_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tbit_q   <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            crcreg_q <= crcreg_d;
            ready_q  <= ready_d;
            clear_q  <= clear_d;
            cvalid_q <= cvalid_d;
            cbit_q   <= cbit_d;
            tvalid_q <= tvalid_d;
            tbit_q   <= tbit_d;
            tlast_q  <= tlast_d;
        end
    end

    assign byte_ready_out = ready_q;
    assign crc_clear_out  = clear_q;
    assign crc_valid_out  = cvalid_q;
    assign crc_bit_out    = cbit_q;
    assign tx_valid_out   = tvalid_q;
    assign tx_bit_out     = tbit_q;
    assign tx_last_out    = tlast_q;

endmodule

// File: tb/tb_crc32_frame_tx.sv
// tb/tb_crc32_frame_tx.sv - scoreboard bench for crc32_frame_tx with plain and inverted-CRC instances
module tb_crc32_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] byte_d = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;

    logic ready0, clr0, cv0, cb0, tv0, tb0, tl0;
    logic ready1, clr1, cv1, cb1, tv1, tb1, tl1;
    logic [31:0] crc_reg0 = 32'h0;
    logic [31:0] crc_reg1 = 32'h0;

    logic [1:0] exp0[$];
    logic [1:0] exp1[$];
    logic [1:0] cap0[$];
    logic [1:0] cap1[$];
    logic [7:0] pkt_q[$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    crc32_frame_tx #(.INVERT_CRC(0), .CRC_WIDTH(32)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .byte_in(byte_d), .byte_valid_in(byte_valid),
        .byte_last_in(byte_last), .byte_ready_out(ready0), .crc_clear_out(clr0),
        .crc_valid_out(cv0), .crc_bit_out(cb0), .crc_in(crc_reg0),
        .tx_valid_out(tv0), .tx_bit_out(tb0), .tx_last_out(tl0)
    );

    crc32_frame_tx #(.INVERT_CRC(1), .CRC_WIDTH(32)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .byte_in(byte_d), .byte_valid_in(byte_valid),
        .byte_last_in(byte_last), .byte_ready_out(ready1), .crc_clear_out(clr1),
        .crc_valid_out(cv1), .crc_bit_out(cb1), .crc_in(crc_reg1),
        .tx_valid_out(tv1), .tx_bit_out(tb1), .tx_last_out(tl1)
    );

    // Bit-serial CRC-32/MPEG-2 stages standing in for the downstream block.
    always @(posedge clk) begin
        if (clr0) crc_reg0 <= 32'hFFFFFFFF;
        else if (cv0) crc_reg0 <= {crc_reg0[30:0], 1'b0} ^ ((crc_reg0[31] ^ cb0) ? 32'h04C11DB7 : 32'h0);
        if (clr1) crc_reg1 <= 32'hFFFFFFFF;
        else if (cv1) crc_reg1 <= {crc_reg1[30:0], 1'b0} ^ ((crc_reg1[31] ^ cb1) ? 32'h04C11DB7 : 32'h0);
    end

    function automatic logic [31:0] crc_calc();
        logic [31:0] c = 32'hFFFFFFFF;
        logic        fb;
        foreach (pkt_q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ pkt_q[i][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_tail(input bit which);
        logic [31:0] c = 32'h0;
        int          n = which ? cap1.size() : cap0.size();
        if (n < 32) return 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) begin
            c = {c[30:0], which ? cap1[n-32+i][0] : cap0[n-32+i][0]};
        end
        return c;
    endfunction

    function automatic int sb_mismatch(input bit which);
        int         m = 0;
        logic [1:0] e, a;
        if (!which) begin
            while (exp0.size() > 0) begin
                e = exp0.pop_front();
                if (cap0.size() == 0) m++;
                else begin a = cap0.pop_front(); if (a !== e) m++; end
            end
            m += cap0.size();
            cap0.delete();
        end else begin
            while (exp1.size() > 0) begin
                e = exp1.pop_front();
                if (cap1.size() == 0) m++;
                else begin a = cap1.pop_front(); if (a !== e) m++; end
            end
            m += cap1.size();
            cap1.delete();
        end
        return m;
    endfunction

    task automatic load_ascii();
        pkt_q.delete();
        for (int i = 1; i <= 9; i++) pkt_q.push_back(8'(8'h30 + i));
    endtask

    // Drives pkt_q, pushing expected frame bits on accept and capturing tx bits each cycle.
    task automatic drive_packet(input logic [31:0] exp_crc, input int stall_len, input int abort_at,
                                output int last_at, output int gaps, output int crcv, output int clrs);
        int idx = 0;
        int acc = -1;
        int stall = 0;
        bit seen = 1'b0;
        last_at = -1; gaps = 0; crcv = 0; clrs = 0;
        exp0.delete(); exp1.delete(); cap0.delete(); cap1.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (tv0) cap0.push_back({tl0, tb0});
            if (tv1) cap1.push_back({tl1, tb1});
            if (cv0) crcv++;
            if (clr0) clrs++;
            if (tv0) seen = 1'b1;
            else if (seen) gaps++;
            if (tl0) begin
                last_at = cyc - acc;
                break;
            end
            if (abort_at >= 0 && acc >= 0 && cyc - acc == abort_at) begin
                rst_n = 1'b0;
                byte_valid = 1'b0;
                break;
            end
            if (idx < pkt_q.size() && stall == 0) begin
                byte_valid = 1'b1;
                byte_d     = pkt_q[idx];
                byte_last  = (idx == pkt_q.size() - 1);
                if (ready0) begin
                    if (idx == 0) acc = cyc;
                    for (int b = 7; b >= 0; b--) begin
                        exp0.push_back({1'b0, pkt_q[idx][b]});
                        exp1.push_back({1'b0, pkt_q[idx][b]});
                    end
                    if (byte_last) begin
                        for (int b = 31; b >= 0; b--) begin
                            exp0.push_back({b == 0, exp_crc[b]});
                            exp1.push_back({b == 0, ~exp_crc[b]});
                        end
                    end
                    idx++;
                    if (idx == 4 && stall_len > 0) stall = stall_len;
                end
            end else begin
                byte_valid = 1'b0;
                byte_last  = 1'b0;
                if (stall > 0 && ready0) stall--;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] o;
        byte_valid = 1'b1; byte_d = 8'h55; byte_last = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            o = {ready0, clr0, cv0, cb0, tv0, tb0, tl0};
            n_total++;
            if (o !== 7'b1000000) $display("FAIL reset_outputs got %b want %b", o, 7'b1000000);
            else n_pass++;
        end
        rst_n = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        o = {ready0, clr0, cv0, cb0, tv0, tb0, tl0};
        n_total++;
        if (o !== 7'b1000000) $display("FAIL reset_no_consume got %b want %b", o, 7'b1000000);
        else n_pass++;
    endtask

    task automatic test_single();
        int la, g, cv, cl, m;
        logic [7:0] p;
        pkt_q.delete();
        pkt_q.push_back(8'hA5);
        drive_packet(crc_calc(), 0, -1, la, g, cv, cl);
        n_total++;
        if (la !== 42) $display("FAIL single_last_cycle got %0d want 42", la);
        else n_pass++;
        p = 8'h00;
        if (cap0.size() >= 8) for (int i = 0; i < 8; i++) p = {p[6:0], cap0[i][0]};
        n_total++;
        if (p !== 8'b10100101) $display("FAIL single_payload got %b want 10100101", p);
        else n_pass++;
        m = sb_mismatch(1'b0);
        n_total++;
        if (m !== 0) $display("FAIL single_scoreboard mismatches %0d want 0", m);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({ready0, tv0} !== 2'b10) $display("FAIL single_idle_after got %b want 10", {ready0, tv0});
        else n_pass++;
    endtask

    task automatic test_check_value();
        int la, g, cv, cl, m;
        logic [31:0] c;
        load_ascii();
        drive_packet(32'h0376E6E7, 0, -1, la, g, cv, cl);
        c = crc_tail(1'b0);
        n_total++;
        if (c !== 32'h0376E6E7) $display("FAIL check_crc got %h want 0376e6e7", c);
        else n_pass++;
        n_total++;
        if (la !== 106) $display("FAIL check_last_cycle got %0d want 106", la);
        else n_pass++;
        n_total++;
        if (g !== 1 || cv !== 72 || cl !== 1)
            $display("FAIL check_contiguous gaps %0d crcv %0d clears %0d want 1 72 1", g, cv, cl);
        else n_pass++;
        m = sb_mismatch(1'b0);
        n_total++;
        if (m !== 0) $display("FAIL check_scoreboard mismatches %0d want 0", m);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int la, g, cv, cl, m;
        logic [31:0] c;
        load_ascii();
        drive_packet(32'h0376E6E7, 5, -1, la, g, cv, cl);
        c = crc_tail(1'b0);
        n_total++;
        if (c !== 32'h0376E6E7) $display("FAIL stall_crc got %h want 0376e6e7", c);
        else n_pass++;
        n_total++;
        if (la !== 111) $display("FAIL stall_last_cycle got %0d want 111", la);
        else n_pass++;
        n_total++;
        if (g !== 6 || cv !== 72) $display("FAIL stall_gaps gaps %0d crcv %0d want 6 72", g, cv);
        else n_pass++;
        m = sb_mismatch(1'b0);
        n_total++;
        if (m !== 0) $display("FAIL stall_scoreboard mismatches %0d want 0", m);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_invert();
        int la, g, cv, cl, m;
        logic [31:0] c;
        load_ascii();
        drive_packet(32'h0376E6E7, 0, -1, la, g, cv, cl);
        c = crc_tail(1'b1);
        n_total++;
        if (c !== 32'hFC891918) $display("FAIL invert_crc got %h want fc891918", c);
        else n_pass++;
        m = sb_mismatch(1'b1);
        n_total++;
        if (m !== 0) $display("FAIL invert_scoreboard mismatches %0d want 0", m);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int la, g, cv, cl, m, lasts;
        logic [6:0] o;
        logic [31:0] c;
        load_ascii();
        drive_packet(32'h0376E6E7, 0, 30, la, g, cv, cl);
        #1;
        o = {ready0, clr0, cv0, cb0, tv0, tb0, tl0};
        n_total++;
        if (o !== 7'b1000000) $display("FAIL abort_async_reset got %b want %b", o, 7'b1000000);
        else n_pass++;
        lasts = 0;
        foreach (cap0[i]) if (cap0[i][1]) lasts++;
        n_total++;
        if (la !== -1 || lasts !== 0 || cap0.size() !== 29)
            $display("FAIL abort_truncated last_at %0d lasts %0d bits %0d want -1 0 29", la, lasts, cap0.size());
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_packet(32'h0376E6E7, 0, -1, la, g, cv, cl);
        c = crc_tail(1'b0);
        n_total++;
        if (c !== 32'h0376E6E7 || la !== 106)
            $display("FAIL abort_second_frame crc %h last %0d want 0376e6e7 106", c, la);
        else n_pass++;
        m = sb_mismatch(1'b0);
        n_total++;
        if (m !== 0) $display("FAIL abort_scoreboard mismatches %0d want 0", m);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_check_value();
        test_stall();
        test_invert();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc32_frame_tx.md
# crc32_frame_tx

Byte-to-bit framer that sits directly upstream of the bit-serial CRC-32/MPEG-2 stage. It accepts a packet as a stream of bytes over a valid/ready handshake. It serializes each byte MSB first onto both the CRC stage input and the transmit bit stream, then appends the 32-bit CRC it reads back from the CRC stage, MSB first. The transmitted frame is payload bits followed by CRC bits, with a `tx_last_out` marker on the final CRC bit.

## Interface
Parameters:
- `INVERT_CRC`, default 0: when 1, the appended CRC is the bitwise complement of the CRC stage value.
- `CRC_WIDTH`, default 32: width of `crc_in` and number of appended bits. The block is only required to work at 32.

Ports:
- `clk_in` in 1: system clock. All state is updated on its rising edge.
- `rst_n_in` in 1: reset, asynchronous and active-low. Asserting it forces the reset state immediately; release is synchronous to `clk_in`.
- `byte_in` in 8: payload byte.
- `byte_valid_in` in 1: `byte_in` and `byte_last_in` are valid.
- `byte_last_in` in 1: this byte is the final byte of the packet.
- `byte_ready_out` out 1: the block accepts the byte this cycle when `byte_valid_in` is also high.
- `crc_clear_out` out 1: synchronous clear to the CRC stage (drives its `rst_in`).
- `crc_valid_out` out 1: `crc_bit_out` is valid. This is the CRC stage's `data_valid_in`.
- `crc_bit_out` out 1: payload bit to the CRC stage (its `data_in`).
- `crc_in` in CRC_WIDTH: current CRC register from the CRC stage (its `data_out`).
- `tx_valid_out` out 1: `tx_bit_out` is valid.
- `tx_bit_out` out 1: serialized frame bit.
- `tx_last_out` out 1: high with the final CRC bit only.

## Operation
- States: IDLE, CLEAR, DATA, WAIT, SETTLE, CRC.
- All outputs are decoded from registered state, shift register and counter. No input reaches an output combinationally.
- **IDLE**
  - `byte_ready_out` = 1.
  - On accept: load `byte_in` into the shift register, load `byte_last_in` into the last flag, set bit counter = 7, go to CLEAR.
- **CLEAR** (1 cycle)
  - `crc_clear_out` = 1; all valids 0.
  - The CRC stage register equals 0xFFFFFFFF after this edge.
  - Next state: DATA.
- **DATA** (8 cycles per byte)
  - `crc_valid_out` = `tx_valid_out` = 1.
  - `crc_bit_out` = `tx_bit_out` = shift[7].
  - Each cycle: shift left, decrement counter.
  - On the bit-0 cycle of a non-last byte, `byte_ready_out` = 1:
    - If a byte is accepted, reload the shift register and counter and stay in DATA. There is no gap between bytes.
    - Otherwise go to WAIT.
  - On the bit-0 cycle of the last byte, `byte_ready_out` = 0 and the next state is SETTLE.
- **WAIT**
  - `byte_ready_out` = 1; all valids 0.
  - On accept: load the byte and go to DATA. CLEAR is not repeated.
- **SETTLE** (1 cycle)
  - All valids 0.
  - Latch `crc_in` into the CRC shift register, complemented if `INVERT_CRC` = 1.
  - Set bit counter = 31. Next state: CRC.
- **CRC** (32 cycles)
  - `tx_valid_out` = 1, `tx_bit_out` = crcreg[31]; shift left each cycle.
  - `crc_valid_out` = 0.
  - `tx_last_out` = 1 when counter = 0; then go to IDLE.
- `byte_valid_in` while `byte_ready_out` = 0 is ignored; the byte is not consumed.
- Minimum packet length is 1 byte. Zero-length packets are not representable.

## Timing
- Reset values:
  - state IDLE, `byte_ready_out` 1.
  - `crc_clear_out`, `crc_valid_out`, `crc_bit_out`, `tx_valid_out`, `tx_bit_out`, `tx_last_out` all 0.
  - Internal registers 0.
- Cycle numbering, for an accept in cycle 0:
  - cycle 1 is CLEAR.
  - Cycles 2..(1+8N) are payload bits for N back-to-back bytes.
  - The next cycle is SETTLE.
  - The following 32 cycles are CRC bits.
  - `tx_last_out` is high in cycle 8N+34.
- `byte_ready_out` rises again in cycle 8N+35 (IDLE). The next packet can be accepted in that same cycle.
- Each stall in WAIT adds exactly the stall cycles plus one bubble-free resume. The first bit after WAIT appears the cycle after accept.
- Reset mid-frame:
  - Outputs return to reset values immediately, without waiting for a clock.
  - The partial frame is dropped; no `tx_last_out` is emitted.
  - The CRC stage is cleared by the next packet's CLEAR.

## Test plan
- **Reset:** hold `rst_n_in` low for 3 cycles, with `byte_valid_in` = 1 -> all outputs at reset values; `byte_ready_out` = 1; no byte consumed before release.
- **Single byte:** send 0xA5 with last -> `tx_bit_out` over 8 valid cycles is 1,0,1,0,0,1,0,1. The next 32 valid bits equal the CRC computed by the bench's `crc32_mpeg2` instance for 0xA5. `tx_last_out` is on the 32nd CRC bit. Total 42 cycles from accept to last.
- **Check value:** send ASCII "123456789" back-to-back -> 72 contiguous payload bits, then the appended CRC bits read 0x0376E6E7 MSB first. `tx_last_out` is in cycle 106 after the first accept.
- **Stall:** same packet with `byte_valid_in` dropped for 5 cycles after byte 4 -> WAIT for 5 cycles with valids low. CRC still 0x0376E6E7; `tx_last_out` delayed by exactly 5 cycles.
- **INVERT_CRC = 1:** "123456789" -> appended bits 0xFC891918.
- **Abort:** assert `rst_n_in` mid-payload, release, send "123456789" -> first frame truncated with no `tx_last_out`; second frame CRC 0x0376E6E7.
